// File: rtl/seg7_pattern_decoder.sv
// Synchronises, debounces and decodes an active-low 7-segment bus into hex events.
// Define SEG7_DEC_DP_EN to add the decimal point (dp_in / out_dp) to the pattern.
module seg7_pattern_decoder #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg_in,
`ifdef SEG7_DEC_DP_EN
    input  logic       dp_in,
    output logic       out_dp,
`endif
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_digit,
    output logic       out_blank,
    output logic       out_err,
    output logic       overrun
);

`ifdef SEG7_DEC_DP_EN
    localparam int W = 8;
    logic [W-1:0] raw;
    assign raw = {dp_in, seg_in};
`else
    localparam int W = 7;
    logic [W-1:0] raw;
    assign raw = seg_in;
`endif

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [W-1:0] IDLE_PAT = '1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

    typedef enum logic {
        TRACK,
        SETTLE
    } state_t;

    logic [W-1:0]  sync_q [SYNC_STAGES];
    logic [W-1:0]  s;
    state_t        state;
    logic [W-1:0]  cand;
    logic [W-1:0]  last_rep;
    logic [CW-1:0] cnt;
    logic          ev;
    logic [W-1:0]  ev_pat;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= IDLE_PAT;
        end else begin
            sync_q[0] <= raw;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // ev is a registered strobe; the output stage consumes it one edge later
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= TRACK;
            cand     <= IDLE_PAT;
            last_rep <= IDLE_PAT;
            cnt      <= '0;
            ev       <= 1'b0;
            ev_pat   <= IDLE_PAT;
        end else begin
            ev <= 1'b0;
            unique case (state)
                TRACK: begin
                    if (s != last_rep) begin
                        state <= SETTLE;
                        cand  <= s;
                        cnt   <= CW'(1);
                    end
                end
                SETTLE: begin
                    if (s == last_rep) begin
                        state <= TRACK;
                    end else if (s != cand) begin
                        cand <= s;
                        cnt  <= CW'(1);
                    end else if (cnt == CNT_MAX) begin
                        ev       <= 1'b1;
                        ev_pat   <= cand;
                        last_rep <= cand;
                        state    <= TRACK;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
            endcase
        end
    end

    logic [3:0] dec_digit;
    logic       dec_blank;
    logic       dec_err;

    always_comb begin
        dec_digit = 4'h0;
        dec_blank = 1'b0;
        dec_err   = 1'b0;
        case (ev_pat[6:0])
            7'h40: dec_digit = 4'h0;
            7'h79: dec_digit = 4'h1;
            7'h24: dec_digit = 4'h2;
            7'h30: dec_digit = 4'h3;
            7'h19: dec_digit = 4'h4;
            7'h12: dec_digit = 4'h5;
            7'h02: dec_digit = 4'h6;
            7'h78: dec_digit = 4'h7;
            7'h00: dec_digit = 4'h8;
            7'h18: dec_digit = 4'h9;
            7'h08: dec_digit = 4'hA;
            7'h03: dec_digit = 4'hB;
            7'h46: dec_digit = 4'hC;
            7'h21: dec_digit = 4'hD;
            7'h06: dec_digit = 4'hE;
            7'h0E: dec_digit = 4'hF;
            7'h7F: dec_blank = 1'b1;
            default: dec_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_digit <= 4'h0;
            out_blank <= 1'b0;
            out_err   <= 1'b0;
            overrun   <= 1'b0;
`ifdef SEG7_DEC_DP_EN
            out_dp    <= 1'b0;
`endif
        end else begin
            overrun <= 1'b0;
            if (ev && (!out_valid || out_ready)) begin
                out_valid <= 1'b1;
                out_digit <= dec_digit;
                out_blank <= dec_blank;
                out_err   <= dec_err;
`ifdef SEG7_DEC_DP_EN
                out_dp    <= ~ev_pat[7];
`endif
            end else begin
                if (ev) overrun <= 1'b1;
                if (out_ready) out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg7_pattern_decoder.sv
// Self-checking bench for seg7_pattern_decoder: directed scenarios plus
// randomized run-length stimulus against a run-based reference model.
module tb_seg7_pattern_decoder;

    localparam int S   = 2;
    localparam int ST  = 4;
    localparam int LAT = S + ST + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] seg_in;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_digit;
    logic       out_blank;
    logic       out_err;
    logic       overrun;
`ifdef SEG7_DEC_DP_EN
    logic       dp_in;
    logic       out_dp;
`endif

    int passed = 0;
    int total  = 0;

    logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                             7'h02, 7'h78, 7'h00, 7'h18, 7'h08, 7'h03,
                             7'h46, 7'h21, 7'h06, 7'h0E};

    seg7_pattern_decoder #(
        .SYNC_STAGES  (S),
        .STABLE_CYCLES(ST)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .seg_in   (seg_in),
`ifdef SEG7_DEC_DP_EN
        .dp_in    (dp_in),
        .out_dp   (out_dp),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_digit(out_digit),
        .out_blank(out_blank),
        .out_err  (out_err),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    // Reference decode straight from the digit table
    function automatic void ref_decode(input logic [6:0] p,
                                       output logic [3:0] d,
                                       output logic b,
                                       output logic e);
        d = 4'h0;
        b = (p == 7'h7F);
        e = !b;
        for (int i = 0; i < 16; i++) begin
            if (tbl[i] == p) begin
                d = 4'(i);
                e = 1'b0;
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Drive v for n cycles; report valid cycles, last event fields, overruns
    task automatic hold(input logic [6:0] v, input int n,
                        output int nev, output logic [3:0] d,
                        output logic b, output logic e, output int novr);
        nev  = 0;
        novr = 0;
        d = 4'hx;
        b = 1'bx;
        e = 1'bx;
        seg_in = v;
        for (int i = 0; i < n; i++) begin
            step();
            if (out_valid) begin
                nev++;
                d = out_digit;
                b = out_blank;
                e = out_err;
            end
            if (overrun) novr++;
        end
    endtask

    task automatic test_reset();
        int vh, oh;
        seg_in = 7'h7F;
        out_ready = 1'b1;
`ifdef SEG7_DEC_DP_EN
        dp_in = 1'b1;
`endif
        do_reset();
        total++;
        if ({out_valid, out_digit, out_blank, out_err, overrun} !== 8'h00)
            $display("FAIL reset_state: got v=%b d=%h b=%b e=%b o=%b want all 0",
                     out_valid, out_digit, out_blank, out_err, overrun);
        else passed++;
`ifdef SEG7_DEC_DP_EN
        total++;
        if (out_dp !== 1'b0) $display("FAIL reset_dp: got %b want 0", out_dp);
        else passed++;
`endif
        vh = 0;
        oh = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (out_valid) vh++;
            if (overrun) oh++;
        end
        total++;
        if (vh != 0) $display("FAIL blank_no_event: valid cycles %0d want 0", vh);
        else passed++;
        total++;
        if (oh != 0) $display("FAIL blank_no_overrun: overrun cycles %0d want 0", oh);
        else passed++;
    endtask

    task automatic test_latency();
        int first, high;
        logic [3:0] d;
        logic b, e;
        first = -1;
        high  = 0;
        d = 4'hx;
        b = 1'bx;
        e = 1'bx;
        seg_in = 7'h24;
        for (int k = 0; k < 30; k++) begin
            step();
            if (out_valid) begin
                if (first < 0) first = k;
                high++;
                d = out_digit;
                b = out_blank;
                e = out_err;
            end
        end
        total++;
        if (first != LAT) $display("FAIL latency: got %0d edges want %0d", first, LAT);
        else passed++;
        total++;
        if (high != 1) $display("FAIL pulse_width: got %0d cycles want 1", high);
        else passed++;
        total++;
        if ({d, b, e} !== {4'h2, 1'b0, 1'b0})
            $display("FAIL digit2: got d=%h b=%b e=%b want d=2 b=0 e=0", d, b, e);
        else passed++;
    endtask

    task automatic test_glitch();
        int nev, novr, tot_ev;
        logic [3:0] d;
        logic b, e;
        tot_ev = 0;
        for (int i = 0; i < 20; i++) begin
            hold((i % 2 == 0) ? 7'h30 : 7'h24, 2, nev, d, b, e, novr);
            tot_ev += nev;
        end
        hold(7'h30, 30, nev, d, b, e, novr);
        tot_ev += nev;
        total++;
        if (tot_ev != 1) $display("FAIL glitch_events: got %0d want 1", tot_ev);
        else passed++;
        total++;
        if (d !== 4'h3) $display("FAIL glitch_digit: got %h want 3", d);
        else passed++;
    endtask

    task automatic test_overrun();
        int nev, novr, bad;
        logic [3:0] d;
        logic b, e;
        out_ready = 1'b0;
        hold(7'h40, 15, nev, d, b, e, novr);
        total++;
        if (out_valid !== 1'b1 || out_digit !== 4'h0)
            $display("FAIL pend_first: got v=%b d=%h want v=1 d=0", out_valid, out_digit);
        else passed++;
        seg_in = 7'h0E;
        novr = 0;
        bad  = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (overrun) novr++;
            if (out_valid !== 1'b1 || out_digit !== 4'h0) bad++;
        end
        total++;
        if (novr != 1) $display("FAIL overrun_count: got %0d want 1", novr);
        else passed++;
        total++;
        if (bad != 0) $display("FAIL pend_held: %0d disturbed cycles want 0", bad);
        else passed++;
        out_ready = 1'b1;
        step();
        total++;
        if (out_valid !== 1'b0) $display("FAIL accept_drop: got v=%b want 0", out_valid);
        else passed++;
        hold(7'h0E, 20, nev, d, b, e, novr);
        total++;
        if (nev != 0) $display("FAIL no_more_event: got %0d events want 0", nev);
        else passed++;
    endtask

    task automatic test_err_blank();
        int nev, novr;
        logic [3:0] d;
        logic b, e;
        hold(7'h55, 15, nev, d, b, e, novr);
        total++;
        if (nev != 1 || {d, b, e} !== {4'h0, 1'b0, 1'b1})
            $display("FAIL err_event: got n=%0d d=%h b=%b e=%b want n=1 d=0 b=0 e=1",
                     nev, d, b, e);
        else passed++;
        hold(7'h7F, 15, nev, d, b, e, novr);
        total++;
        if (nev != 1 || {d, b, e} !== {4'h0, 1'b1, 1'b0})
            $display("FAIL blank_event: got n=%0d d=%h b=%b e=%b want n=1 d=0 b=1 e=0",
                     nev, d, b, e);
        else passed++;
        hold(7'h12, 4, nev, d, b, e, novr);
        rst = 1'b1;
        seg_in = 7'h7F;
        step();
        step();
        rst = 1'b0;
        hold(7'h7F, 30, nev, d, b, e, novr);
        total++;
        if (nev != 0) $display("FAIL rst_mid_settle: got %0d events want 0", nev);
        else passed++;
    endtask

    task automatic test_random();
        logic [6:0] vals [40];
        int         lens [40];
        logic [6:0] expq [$];
        logic [6:0] prev, last, p;
        logic [3:0] rd;
        logic       rb, re;
        int         bad_ev, ovr, r;
        out_ready = 1'b1;
        seg_in = 7'h7F;
        do_reset();
        prev = 7'h7F;
        last = 7'h7F;
        // A run of ST+1 or more identical samples that differs from the last
        // reported pattern yields exactly one event; shorter runs yield none.
        for (int i = 0; i < 40; i++) begin
            do begin
                r = $urandom_range(0, 3);
                if (r < 2) vals[i] = tbl[$urandom_range(0, 15)];
                else if (r == 2) vals[i] = 7'h7F;
                else vals[i] = 7'($urandom);
            end while (vals[i] == prev);
            prev = vals[i];
            if ($urandom_range(0, 1) == 0) lens[i] = $urandom_range(1, ST);
            else lens[i] = $urandom_range(ST + 1, ST + 8);
            if (i == 39) lens[i] += LAT + 4;
            if (lens[i] >= ST + 1 && vals[i] != last) begin
                expq.push_back(vals[i]);
                last = vals[i];
            end
        end
        bad_ev = 0;
        ovr = 0;
        for (int i = 0; i < 40; i++) begin
            seg_in = vals[i];
            for (int c = 0; c < lens[i]; c++) begin
                step();
                if (overrun) ovr++;
                if (out_valid) begin
                    total++;
                    if (expq.size() == 0) begin
                        $display("FAIL rand_unexpected: got d=%h b=%b e=%b want no event",
                                 out_digit, out_blank, out_err);
                    end else begin
                        p = expq.pop_front();
                        ref_decode(p, rd, rb, re);
                        if ({out_digit, out_blank, out_err} !== {rd, rb, re})
                            $display("FAIL rand_event pat=%h: got d=%h b=%b e=%b want d=%h b=%b e=%b",
                                     p, out_digit, out_blank, out_err, rd, rb, re);
                        else passed++;
                    end
                end
            end
        end
        bad_ev = expq.size();
        total++;
        if (bad_ev != 0) $display("FAIL rand_missing: %0d events not seen want 0", bad_ev);
        else passed++;
        total++;
        if (ovr != 0) $display("FAIL rand_overrun: got %0d want 0", ovr);
        else passed++;
    endtask

`ifdef SEG7_DEC_DP_EN
    task automatic test_dp();
        int nev, novr;
        logic [3:0] d;
        logic b, e;
        out_ready = 1'b1;
        dp_in = 1'b1;
        seg_in = 7'h7F;
        do_reset();
        hold(7'h79, 15, nev, d, b, e, novr);
        total++;
        if (nev != 1 || d !== 4'h1 || out_dp !== 1'b0)
            $display("FAIL dp_off: got n=%0d d=%h dp=%b want n=1 d=1 dp=0", nev, d, out_dp);
        else passed++;
        dp_in = 1'b0;
        hold(7'h79, 15, nev, d, b, e, novr);
        total++;
        if (nev != 1 || d !== 4'h1 || out_dp !== 1'b1)
            $display("FAIL dp_on: got n=%0d d=%h dp=%b want n=1 d=1 dp=1", nev, d, out_dp);
        else passed++;
    endtask
`endif

    initial begin
        rst = 1'b1;
        seg_in = 7'h7F;
        out_ready = 1'b1;
`ifdef SEG7_DEC_DP_EN
        dp_in = 1'b1;
`endif
        test_reset();
        test_latency();
        test_glitch();
        test_overrun();
        test_err_blank();
        test_random();
`ifdef SEG7_DEC_DP_EN
        test_dp();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
